// File: rtl/mario_pause_arbiter.sv
// Pause/high-score sequencer: merges pause sources into one CPU hold, waits for a
// safe bus boundary, hands the work-RAM port to the high-score engine and times the screen dim.
module mario_pause_arbiter #(
  parameter int DIM_CYCLES   = 480000000,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic I_CLK_48M,
  input  logic I_RESETn,
  input  logic I_HS_REQ,
  input  logic I_USER_PAUSE,
  input  logic I_OSD_PAUSE,
  input  logic I_VBLANK,
  input  logic I_CPU_IDLE,
  output logic O_CPU_HOLD,
  output logic O_HS_GRANT,
  output logic O_DIM,
  output logic O_FORCED
);

  localparam int               DIM_W     = $clog2(DIM_CYCLES + 1);
  localparam logic [DIM_W-1:0] DIM_MAX   = DIM_W'(DIM_CYCLES);
  localparam logic [DIM_W-1:0] DIM_ONE   = DIM_W'(1);
  localparam logic [7:0]       IDLE_LAST = 8'(IDLE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_WAIT,
    ST_HELD,
    ST_GRANT,
    ST_RELEASE
  } state_e;

  state_e           state_q, state_d;
  logic             utog_q, utog_d;
  logic             usr_dly_q, usr_dly_d;
  logic [7:0]       idle_cnt_q, idle_cnt_d;
  logic [DIM_W-1:0] dim_cnt_q, dim_cnt_d;
  logic             hold_q, hold_d;
  logic             grant_q, grant_d;
  logic             dim_q, dim_d;
  logic             forced_q, forced_d;
  logic             pd;

  always_comb begin
    usr_dly_d  = I_USER_PAUSE;
    utog_d     = utog_q ^ (I_USER_PAUSE & ~usr_dly_q);
    pd         = utog_q | I_OSD_PAUSE;
    state_d    = state_q;
    forced_d   = forced_q;
    idle_cnt_d = 8'd0;

    case (state_q)
      ST_RUN: begin
        forced_d = 1'b0;
        // High-score requests only start a hold inside vblank; pauses start one anytime.
        if (pd | (I_HS_REQ & I_VBLANK)) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        idle_cnt_d = idle_cnt_q + 8'd1;
        if (I_CPU_IDLE) begin
          state_d  = ST_HELD;
          forced_d = 1'b0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d  = ST_HELD;
          forced_d = 1'b1;
        end
      end
      ST_HELD: begin
        if (I_HS_REQ) begin
          state_d = ST_GRANT;
        end else if (!pd) begin
          state_d  = ST_RELEASE;
          forced_d = 1'b0;
        end
      end
      ST_GRANT: begin
        // A transfer in progress is never cut short by a pause change.
        if (!I_HS_REQ) state_d = ST_HELD;
      end
      ST_RELEASE: begin
        state_d  = ST_RUN;
        forced_d = 1'b0;
      end
      default: begin
        state_d  = ST_RUN;
        forced_d = 1'b0;
      end
    endcase

    hold_d  = (state_d == ST_WAIT) | (state_d == ST_HELD) | (state_d == ST_GRANT);
    grant_d = (state_d == ST_GRANT);

    // Counter reads 0 in the first hold cycle, so it hits DIM_MAX exactly DIM_CYCLES later.
    if (hold_d & hold_q) begin
      dim_cnt_d = (dim_cnt_q == DIM_MAX) ? DIM_MAX : dim_cnt_q + DIM_ONE;
    end else begin
      dim_cnt_d = '0;
    end
    dim_d = hold_d & (dim_cnt_d == DIM_MAX);
  end

  always_ff @(posedge I_CLK_48M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      state_q    <= ST_RUN;
      utog_q     <= 1'b0;
      usr_dly_q  <= 1'b0;
      idle_cnt_q <= 8'd0;
      dim_cnt_q  <= '0;
      hold_q     <= 1'b0;
      grant_q    <= 1'b0;
      dim_q      <= 1'b0;
      forced_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      utog_q     <= utog_d;
      usr_dly_q  <= usr_dly_d;
      idle_cnt_q <= idle_cnt_d;
      dim_cnt_q  <= dim_cnt_d;
      hold_q     <= hold_d;
      grant_q    <= grant_d;
      dim_q      <= dim_d;
      forced_q   <= forced_d;
    end
  end

  assign O_CPU_HOLD = hold_q;
  assign O_HS_GRANT = grant_q;
  assign O_DIM      = dim_q;
  assign O_FORCED   = forced_q;

endmodule

// File: doc/mario_pause_arbiter.md
# mario_pause_arbiter

Sequencer for the pause and high-score RAM-sharing path of the Mario Bros core. It merges the three pause sources (high-score requests, the user pause button and the OSD-open pause) into one CPU hold. It waits for the CPU to reach a safe bus boundary, then hands the work-RAM port to the high-score engine. It also drives the screen-dim timer. It sits between the top-level input and hiscore logic and `mario_top`'s CPU clock-enable and RAM address/data mux.

## Interface
- `DIM_CYCLES`, default 480000000: hold cycles before `O_DIM` asserts (10 s at 48 MHz).
- `IDLE_TIMEOUT`, default 64: maximum cycles spent waiting for `I_CPU_IDLE` before the hold is forced.
- `I_CLK_48M`  in  1  system clock; the only clock.
- `I_RESETn`  in  1  reset, asynchronous, active-low.
- `I_HS_REQ`  in  1  high-score engine requests the RAM port (level).
- `I_USER_PAUSE`  in  1  user pause button (level); each rising edge toggles the user pause.
- `I_OSD_PAUSE`  in  1  OSD is open and pause-on-OSD is enabled (level).
- `I_VBLANK`  in  1  vertical blank from the video timing.
- `I_CPU_IDLE`  in  1  CPU is at a bus-cycle boundary with the clock enable held.
- `O_CPU_HOLD`  out  1  stall the CPU clock enable.
- `O_HS_GRANT`  out  1  RAM port mux selects the high-score engine.
- `O_DIM`  out  1  dim the video output.
- `O_FORCED`  out  1  current hold was entered by timeout, not by `I_CPU_IDLE`.

## Operation
- All outputs are registered. On reset every output is 0, the state is RUN, the user toggle is 0 and all counters are 0.
- User toggle: a rising edge of `I_USER_PAUSE`, detected against a 1-cycle delayed copy, inverts `utog` in any state.
- Pause demand: `pd = utog | I_OSD_PAUSE`.
- RUN
  - Hold = 0, grant = 0.
  - Go to WAIT if `pd`, or if `I_HS_REQ & I_VBLANK`.
  - `I_HS_REQ` outside vblank is ignored until vblank.
- WAIT
  - Hold = 1; the idle counter increments each cycle.
  - Go to HELD when `I_CPU_IDLE` = 1.
  - Otherwise, when the counter reaches `IDLE_TIMEOUT`-1, go to HELD with `O_FORCED` set.
- HELD
  - Hold = 1.
  - If `I_HS_REQ`, go to GRANT. There is no vblank requirement here, because the CPU is already stopped.
  - Else if `!pd`, go to RELEASE.
  - Else stay in HELD.
- GRANT
  - Hold = 1, grant = 1.
  - When `I_HS_REQ` drops, go to HELD; grant drops on that transition.
  - Grant and `!pd` can never exit to RUN directly; the path always passes through HELD.
- RELEASE
  - Hold = 0, grant = 0, `O_FORCED` cleared.
  - Lasts exactly 1 cycle, then RUN. New requests are not sampled in this cycle.
- Dim counter
  - Increments while `O_CPU_HOLD` = 1 and saturates at `DIM_CYCLES`.
  - Cleared to 0 in any cycle where `O_CPU_HOLD` = 0.
  - `O_DIM` = (counter == `DIM_CYCLES`). Counter width is `$clog2(DIM_CYCLES+1)`.
- Idle counter: 8 bits, cleared on every entry to WAIT.
- Simultaneous `pd` and `I_HS_REQ` in RUN: a single WAIT entry; HELD then grants immediately.
- `pd` falling while in GRANT: the grant is kept until `I_HS_REQ` drops. The high-score transfer is never truncated by a pause change.
- `utog` toggling while in WAIT: WAIT still completes to HELD, which then releases if nothing is pending.
- Reset asserted mid-operation: hold, grant, dim and forced all go to 0 immediately (asynchronous), and the state returns to RUN.

## Timing
- Request sampled in RUN at cycle t → `O_CPU_HOLD`=1 at t+1.
- `I_CPU_IDLE`=1 at t+1 → HELD at t+2.
- HELD with `I_HS_REQ` → `O_HS_GRANT`=1 at t+3. Minimum request-to-grant latency is 3 cycles.
- Timeout path: `O_CPU_HOLD` is asserted for at most `IDLE_TIMEOUT`+1 cycles before HELD.
- `I_HS_REQ` deassert at cycle u in GRANT → `O_HS_GRANT`=0 at u+1.
- With no pause pending: RELEASE at u+2, hold = 0 at u+2, RUN at u+3.
- `O_HS_GRANT`=1 always implies `O_CPU_HOLD`=1 in the same cycle.
- `O_DIM` asserts exactly `DIM_CYCLES` cycles after `O_CPU_HOLD` rises, and falls in the first cycle hold is 0.

## Test plan
- Hiscore in vblank:
  - Stimulus: `I_VBLANK`=1, `I_CPU_IDLE`=1, pulse `I_HS_REQ` high for 10 cycles.
  - Required: hold=1 at +1, grant=1 at +3 through the cycle after the request drops, RELEASE for 1 cycle, RUN afterwards.
- Hiscore outside vblank:
  - Stimulus: `I_HS_REQ`=1 with `I_VBLANK`=0 for 100 cycles, then `I_VBLANK`=1.
  - Required: hold stays 0 throughout, rises 1 cycle after vblank.
- Idle timeout:
  - Stimulus: `IDLE_TIMEOUT`=4, `I_CPU_IDLE`=0, `I_OSD_PAUSE`=1.
  - Required: HELD after 4 WAIT cycles, `O_FORCED`=1; `O_FORCED` clears in RELEASE after the OSD closes.
- User toggle with hiscore:
  - Stimulus: two `I_USER_PAUSE` edges 50 cycles apart, `I_HS_REQ` raised during the hold.
  - Required: grant is held past the second edge until `I_HS_REQ` drops, then release.
- Dim and reset:
  - Stimulus: `DIM_CYCLES`=20, `I_OSD_PAUSE`=1; assert `I_RESETn`=0 at cycle 25.
  - Required: `O_DIM`=1 from hold+20; all outputs 0 immediately at reset.
